axi_frame_rd_master: RTL and testbench

- AXI4 read master that fetches one video frame from DDR in fixed-length INCR bursts.
- Pushes every returned data beat into the write side of the AXI output FIFO; the display/output logic drains the read side.
- Issue is credit-based on the FIFO's write water level, so a beat is never offered to a full FIFO.
- Runs entirely in the AXI clock domain.

---
 rtl/axi_rd_pkg.sv | 23 ++
 rtl/rd_credit_ctr.sv | 48 ++++
 rtl/axi_frame_rd_master.sv | 135 +++++++++++++
 tb/tb_axi_frame_rd_master.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_pkg.sv
// Shared AXI read constants, the issue-FSM state type and a constant-width helper
// used by the frame read master and its credit counter.
package axi_rd_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    ADDR,
    DRAIN
  } rd_state_e;

  // Ceiling log2; clog2(1) is 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/rd_credit_ctr.sv
// Tracks beats and bursts requested but not yet returned, and decides whether the
// next burst of req_len beats still fits in the FIFO with SLACK beats of headroom.
module rd_credit_ctr
  import axi_rd_pkg::*;
#(
  parameter int BURST_LEN        = 16,
  parameter int MAX_OUTSTANDING  = 2,
  parameter int FIFO_DEPTH_WIDTH = 10,
  parameter int SLACK            = 4,
  parameter int LEN_W            = clog2(BURST_LEN + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [LEN_W-1:0]          req_len,
  input  logic                      ar_fire,
  input  logic [LEN_W-1:0]          ar_beats,
  input  logic                      r_fire,
  input  logic                      r_last,
  input  logic [FIFO_DEPTH_WIDTH:0] water_level,
  output logic                      permit
);

  localparam int OB_W  = clog2(MAX_OUTSTANDING * BURST_LEN + 1);
  localparam int OBU_W = clog2(MAX_OUTSTANDING + 1);
  localparam int CMP_W = FIFO_DEPTH_WIDTH + 2;
  localparam logic [CMP_W-1:0] LIMIT = CMP_W'((1 << FIFO_DEPTH_WIDTH) - SLACK);

  logic [OB_W-1:0]  outstanding_beats;
  logic [OBU_W-1:0] outstanding_bursts;
  logic [CMP_W-1:0] demand;

  assign demand = CMP_W'(water_level) + CMP_W'(outstanding_beats) + CMP_W'(req_len);
  assign permit = (demand <= LIMIT) && (32'(outstanding_bursts) < MAX_OUTSTANDING);

  // NOTE: sequential state uses <= so every register samples pre-edge values;
  // a same-cycle AR handshake and R beat both land (net += len - 1).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outstanding_beats  <= '0;
      outstanding_bursts <= '0;
    end else begin
      outstanding_beats  <= outstanding_beats + (ar_fire ? OB_W'(ar_beats) : '0)
                            - OB_W'(r_fire);
      outstanding_bursts <= outstanding_bursts + OBU_W'(ar_fire) - OBU_W'(r_fire && r_last);
    end
  end

endmodule

// File: rtl/axi_frame_rd_master.sv
// AXI4 read master fetching one frame in INCR bursts into the output FIFO,
// issuing only when the FIFO water level leaves room for every outstanding beat.
module axi_frame_rd_master
  import axi_rd_pkg::*;
#(
  parameter int ADDR_WIDTH       = 28,
  parameter int DATA_WIDTH       = 128,
  parameter int BURST_LEN        = 16,
  parameter int FRAME_BEATS      = 259200,
  parameter int FIFO_DEPTH_WIDTH = 10,
  parameter int MAX_OUTSTANDING  = 2,
  parameter int SLACK            = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        frame_start,
  input  logic [ADDR_WIDTH-1:0]       base_addr,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        overrun,
  output logic                        rresp_err,
  output logic [ADDR_WIDTH-1:0]       araddr,
  output logic [7:0]                  arlen,
  output logic [2:0]                  arsize,
  output logic [1:0]                  arburst,
  output logic                        arvalid,
  input  logic                        arready,
  input  logic [DATA_WIDTH-1:0]       rdata,
  input  logic [1:0]                  rresp,
  input  logic                        rlast,
  input  logic                        rvalid,
  output logic                        rready,
  output logic [DATA_WIDTH-1:0]       fifo_wr_data,
  output logic                        fifo_wr_en,
  input  logic                        fifo_wr_full,
  input  logic [FIFO_DEPTH_WIDTH:0]   fifo_wr_water_level
);

  localparam int SIZE_LOG2 = clog2(DATA_WIDTH / 8);
  localparam int FB_W      = clog2(FRAME_BEATS + 1);
  localparam int LEN_W     = clog2(BURST_LEN + 1);

  rd_state_e       state;
  logic [FB_W-1:0] beats_to_request;
  logic [FB_W-1:0] beats_to_receive;
  logic [LEN_W-1:0] cur_len;
  logic [LEN_W-1:0] ar_beats;
  logic            permit;
  logic            ar_fire;
  logic            r_fire;

  assign arsize       = 3'(SIZE_LOG2);
  assign arburst      = AXI_BURST_INCR;
  assign rready       = rst_n & busy & ~fifo_wr_full;
  assign r_fire       = rvalid & rready;
  assign fifo_wr_en   = r_fire;
  assign fifo_wr_data = rdata;
  assign frame_done   = r_fire && (beats_to_receive == FB_W'(1));
  assign ar_fire      = arvalid & arready;
  assign ar_beats     = LEN_W'(arlen) + LEN_W'(1);

  // NOTE: give cur_len a value before the conditional so no path leaves it unassigned.
  always_comb begin
    cur_len = LEN_W'(BURST_LEN);
    if (32'(beats_to_request) < BURST_LEN) cur_len = LEN_W'(beats_to_request);
  end

  rd_credit_ctr #(
    .BURST_LEN       (BURST_LEN),
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .FIFO_DEPTH_WIDTH(FIFO_DEPTH_WIDTH),
    .SLACK           (SLACK),
    .LEN_W           (LEN_W)
  ) u_credit (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_len    (cur_len),
    .ar_fire    (ar_fire),
    .ar_beats   (ar_beats),
    .r_fire     (r_fire),
    .r_last     (rlast),
    .water_level(fifo_wr_water_level),
    .permit     (permit)
  );

  // NOTE: reset is sampled on the clock edge only; the slave is reset alongside.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      busy             <= 1'b0;
      overrun          <= 1'b0;
      rresp_err        <= 1'b0;
      arvalid          <= 1'b0;
      araddr           <= '0;
      arlen            <= '0;
      beats_to_request <= '0;
      beats_to_receive <= '0;
    end else begin
      if (frame_start && busy) overrun <= 1'b1;
      if (r_fire && (rresp != AXI_RESP_OKAY)) rresp_err <= 1'b1;
      if (r_fire) beats_to_receive <= beats_to_receive - FB_W'(1);

      case (state)
        IDLE: if (frame_start) begin
          araddr           <= base_addr;
          beats_to_request <= FB_W'(FRAME_BEATS);
          beats_to_receive <= FB_W'(FRAME_BEATS);
          busy             <= 1'b1;
          state            <= CHECK;
        end
        CHECK: if (beats_to_request == '0) begin
          state <= DRAIN;
        end else if (permit) begin
          arlen   <= 8'(cur_len - LEN_W'(1));
          arvalid <= 1'b1;
          state   <= ADDR;
        end
        ADDR: if (arready) begin
          arvalid          <= 1'b0;
          araddr           <= araddr + (ADDR_WIDTH'(ar_beats) << SIZE_LOG2);
          beats_to_request <= beats_to_request - FB_W'(ar_beats);
          state            <= CHECK;
        end
        DRAIN: ;
      endcase

      // The last beat can land while still in CHECK, so completion overrides any state.
      if (frame_done) begin
        busy  <= 1'b0;
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_axi_frame_rd_master.sv
// Scoreboarded bench: a randomized AXI slave model feeds beats, expected bursts come
// from a frame-level burst plan, and a monitor checks AR, FIFO writes and credit rules.
module tb_axi_frame_rd_master;

  localparam int AW = 28, DW = 128, BL = 16, FB = 40, FDW = 6, MO = 2, SL = 4;
  localparam int BYTES = DW / 8;
  localparam int CREDIT_LIMIT = (1 << FDW) - SL;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           frame_start;
  logic [AW-1:0]  base_addr;
  logic           busy, frame_done, overrun, rresp_err;
  logic [AW-1:0]  araddr;
  logic [7:0]     arlen;
  logic [2:0]     arsize;
  logic [1:0]     arburst;
  logic           arvalid, arready;
  logic [DW-1:0]  rdata;
  logic [1:0]     rresp;
  logic           rlast, rvalid, rready;
  logic [DW-1:0]  fifo_wr_data;
  logic           fifo_wr_en, fifo_wr_full;
  logic [FDW:0]   fifo_wr_water_level;

  always #5 clk = ~clk;

  axi_frame_rd_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL), .FRAME_BEATS(FB),
    .FIFO_DEPTH_WIDTH(FDW), .MAX_OUTSTANDING(MO), .SLACK(SL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .base_addr(base_addr),
    .busy(busy), .frame_done(frame_done), .overrun(overrun), .rresp_err(rresp_err),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rvalid(rvalid), .rready(rready), .fifo_wr_data(fifo_wr_data),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_full(fifo_wr_full),
    .fifo_wr_water_level(fifo_wr_water_level)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    len;
  } ar_t;

  ar_t           exp_ar_q[$];
  logic [DW-1:0] exp_wr_q[$];

  int checks = 0;
  int errors = 0;

  // Knobs written by the main sequence, read by the slave model.
  bit r_en;
  int err_beat;

  // Monitor-owned state, read by the slave model and main sequence.
  bit ar_fire_f, r_fire_f;
  int ar_len_f;
  int out_beats, out_bursts, wr_in_frame;
  int ar_count = 0, arvalid_cycles = 0, frames_done = 0, total_wr = 0;
  bit done_pending;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_arvalid"}, arvalid, 0);
    check({tag, "_araddr"}, araddr, 0);
    check({tag, "_arlen"}, arlen, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_rresp_err"}, rresp_err, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_rready"}, rready, 0);
    check({tag, "_wr_en"}, fifo_wr_en, 0);
    check({tag, "_arsize"}, arsize, 3'd4);
    check({tag, "_arburst"}, arburst, 2'b01);
  endtask

  // Burst plan from the frame rules: full bursts, then a short remainder, byte-stepped.
  task automatic start_frame(input logic [AW-1:0] base, input bit expect_ars);
    int rem;
    logic [AW-1:0] a;
    @(posedge clk); #1;
    if (expect_ars) begin
      rem = FB;
      a = base;
      while (rem > 0) begin
        int l;
        l = (rem < BL) ? rem : BL;
        exp_ar_q.push_back('{addr: a, len: 8'(l - 1)});
        a = a + AW'(l * BYTES);
        rem -= l;
      end
    end
    base_addr = base;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic wait_frame(input string tag, input int budget);
    int f0, w0;
    f0 = frames_done;
    w0 = total_wr - wr_in_frame;
    for (int i = 0; i < budget && frames_done == f0; i++) @(posedge clk);
    #1;
    check({tag, "_completed"}, frames_done != f0, 1);
    check({tag, "_beats"}, total_wr - w0, FB);
    check({tag, "_wr_q_empty"}, exp_wr_q.size(), 0);
    check({tag, "_ar_q_empty"}, exp_ar_q.size(), 0);
  endtask

  // Monitor: outputs are stable at negedge, so what is seen here fires at the next posedge.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_ar_q.delete();
        exp_wr_q.delete();
        ar_fire_f = 0; r_fire_f = 0;
        out_beats = 0; out_bursts = 0; wr_in_frame = 0;
        done_pending = 0;
      end else begin
        if (done_pending) begin
          check("busy_falls_after_done", busy, 0);
          done_pending = 0;
        end
        ar_fire_f = arvalid && arready;
        r_fire_f  = fifo_wr_en;
        if (arvalid) arvalid_cycles++;
        if (fifo_wr_full) begin
          check("rready_while_full", rready, 0);
          check("wr_en_while_full", fifo_wr_en, 0);
        end
        check("wr_en_is_rvalid_and_rready", fifo_wr_en, rvalid && rready);
        if (ar_fire_f) begin
          check("ar_expected", exp_ar_q.size() != 0, 1);
          if (exp_ar_q.size() != 0) begin
            ar_t e;
            e = exp_ar_q.pop_front();
            check("araddr", araddr, e.addr);
            check("arlen", arlen, e.len);
          end
          check("ar_credit", (int'(fifo_wr_water_level) + out_beats + int'(arlen) + 1
                              <= CREDIT_LIMIT) && (out_bursts < MO), 1);
          ar_len_f = int'(arlen);
          ar_count++;
          out_beats += int'(arlen) + 1;
          out_bursts++;
        end
        if (r_fire_f) begin
          check("wr_expected", exp_wr_q.size() != 0, 1);
          if (exp_wr_q.size() != 0) check("fifo_wr_data", fifo_wr_data, exp_wr_q.pop_front());
          wr_in_frame++;
          total_wr++;
          check("frame_done_on_write", frame_done, wr_in_frame == FB);
          if (wr_in_frame == FB) begin
            frames_done++;
            wr_in_frame = 0;
            done_pending = 1;
          end
          out_beats--;
          if (rlast) out_bursts--;
        end else begin
          check("frame_done_without_write", frame_done, 0);
        end
      end
    end
  end

  // AXI slave R side: queues accepted bursts, presents random beats in order.
  initial begin : slave_r
    int bursts[$];
    int beat_idx, frame_beat;
    rvalid = 0; rlast = 0; rdata = '0; rresp = 2'b00;
    beat_idx = 0; frame_beat = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        bursts.delete();
        rvalid = 0; rlast = 0;
        beat_idx = 0; frame_beat = 0;
      end else begin
        if (ar_fire_f) bursts.push_back(ar_len_f);
        if (r_fire_f) begin
          rvalid = 0;
          if (rlast) begin
            void'(bursts.pop_front());
            beat_idx = 0;
          end else begin
            beat_idx++;
          end
        end
        if (!rvalid && r_en && bursts.size() != 0) begin
          frame_beat = (frame_beat % FB) + 1;
          rvalid = 1;
          rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
          rlast = (beat_idx == bursts[0]);
          rresp = (frame_beat == err_beat) ? 2'b10 : 2'b00;
          exp_wr_q.push_back(rdata);
        end
      end
    end
  end

  initial begin : main
    int a0, v0, w0;
    rst_n = 0; frame_start = 0; base_addr = '0; arready = 1;
    fifo_wr_full = 0; fifo_wr_water_level = '0; r_en = 1; err_beat = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_cleared("reset");
    @(posedge clk); #1 rst_n = 1;
    repeat (2) @(posedge clk);

    // Plain frame: 0x100/0x200/0x300 with lengths 15/15/7.
    start_frame(28'h100, 1);
    check("busy_after_start", busy, 1);
    wait_frame("frame_basic", 400);
    check("overrun_clean", overrun, 0);
    check("rresp_err_clean", rresp_err, 0);

    // Water level 48: 48+0+16 > 60 blocks issue; 28+0+16 fits.
    @(posedge clk); #1 fifo_wr_water_level = 7'd48;
    v0 = arvalid_cycles;
    start_frame(28'h2000, 1);
    repeat (10) @(posedge clk);
    check("no_ar_at_high_water", arvalid_cycles - v0, 0);
    #1 fifo_wr_water_level = 7'd28;
    @(negedge clk);
    @(negedge clk);
    check("ar_after_water_drop", arvalid, 1);
    wait_frame("frame_water", 600);
    @(posedge clk); #1 fifo_wr_water_level = '0;

    // FIFO full for 5 cycles mid-frame: monitor checks rready/wr_en stay low.
    w0 = total_wr;
    start_frame(28'h3000, 1);
    for (int i = 0; i < 200 && total_wr - w0 < 5; i++) @(posedge clk);
    #1 fifo_wr_full = 1;
    repeat (5) @(posedge clk);
    #1 fifo_wr_full = 0;
    wait_frame("frame_full", 600);

    // R stalled: only MAX_OUTSTANDING bursts go out until beats return.
    r_en = 0;
    a0 = ar_count;
    start_frame(28'h5000, 1);
    for (int i = 0; i < 100 && ar_count - a0 < 2; i++) @(posedge clk);
    repeat (10) @(posedge clk);
    check("ar_limit_while_stalled", ar_count - a0, MO);
    #1 r_en = 1;
    wait_frame("frame_stall", 600);

    // Overrun mid-frame and an error response on beat 7.
    err_beat = 7;
    start_frame(28'h8000, 1);
    start_frame(28'habc0, 0);
    @(negedge clk);
    check("overrun_set", overrun, 1);
    wait_frame("frame_overrun", 600);
    check("rresp_err_set", rresp_err, 1);
    check("overrun_sticky", overrun, 1);
    err_beat = 0;

    // Reset after the second AR, then a clean restart at a new base.
    a0 = ar_count;
    start_frame(28'h1000, 1);
    for (int i = 0; i < 100 && ar_count - a0 < 2; i++) @(posedge clk);
    #1 rst_n = 0;
    @(posedge clk);
    @(negedge clk);
    check_cleared("midframe_reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    repeat (2) @(posedge clk);
    start_frame(28'h4000, 1);
    wait_frame("frame_after_reset", 400);
    check("overrun_after_reset", overrun, 0);

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
